// File: rtl/jogador_automatico_exp6.sv
// Automatic player for the exp6 memory game: replays the 16-entry sequence round by
// round on jogar/botoes, optionally injects one wrong press, and reports the outcome.
module jogador_automatico_exp6 #(
  parameter int unsigned PRESS_CYCLES = 5,
  parameter int unsigned GAP_CYCLES   = 5,
  parameter int unsigned START_CYCLES = 5,
  parameter int unsigned WAIT_CYCLES  = 64,
  parameter int unsigned ERRO_RODADA  = 16,
  parameter int unsigned ERRO_JOGADA  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       fim,
  output logic [1:0] resultado,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada,
  output logic [2:0] db_estado
);

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] INICIA    = 3'd1;
  localparam logic [2:0] ESPERA    = 3'd2;
  localparam logic [2:0] PRESSIONA = 3'd3;
  localparam logic [2:0] SOLTA     = 3'd4;
  localparam logic [2:0] PROXIMA   = 3'd5;
  localparam logic [2:0] AGUARDA   = 3'd6;
  localparam logic [2:0] FIM       = 3'd7;

  localparam logic [7:0] PRESS_LIM = 8'(PRESS_CYCLES - 32'd1);
  localparam logic [7:0] GAP_LIM   = 8'(GAP_CYCLES - 32'd1);
  localparam logic [7:0] START_LIM = 8'(START_CYCLES - 32'd1);
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_CYCLES - 32'd1);
  localparam bit         ERRO_ATIVO = (ERRO_RODADA < 32'd16) && (ERRO_JOGADA <= ERRO_RODADA);
  localparam logic [3:0] ERRO_R    = 4'(ERRO_RODADA);
  localparam logic [3:0] ERRO_J    = 4'(ERRO_JOGADA);

  function automatic logic [3:0] rom_valor(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_valor = 4'b0001;
      4'd1:    rom_valor = 4'b0010;
      4'd2:    rom_valor = 4'b0100;
      4'd3:    rom_valor = 4'b1000;
      4'd4:    rom_valor = 4'b0100;
      4'd5:    rom_valor = 4'b0010;
      4'd6:    rom_valor = 4'b0001;
      4'd7:    rom_valor = 4'b0001;
      4'd8:    rom_valor = 4'b0010;
      4'd9:    rom_valor = 4'b0010;
      4'd10:   rom_valor = 4'b0100;
      4'd11:   rom_valor = 4'b0100;
      4'd12:   rom_valor = 4'b1000;
      4'd13:   rom_valor = 4'b1000;
      4'd14:   rom_valor = 4'b0001;
      4'd15:   rom_valor = 4'b0100;
      default: rom_valor = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    rotl1 = {v[2:0], v[3]};
  endfunction

  logic [2:0] estado_r, estado_s;
  logic [3:0] rodada_r, rodada_s;
  logic [3:0] jogada_r, jogada_s;
  logic [7:0] contador_r, contador_s;
  logic [1:0] resultado_s;
  logic       monitora_s;
  logic       detecta_s;
  logic [3:0] valor_s;

  assign monitora_s = (estado_r != OCIOSO) && (estado_r != FIM);
  assign detecta_s  = monitora_s && (ganhou || perdeu);

  // Button value for the current play, with the single injected error
  always_comb begin
    valor_s = rom_valor(jogada_r);
    if (ERRO_ATIVO && (rodada_r == ERRO_R) && (jogada_r == ERRO_J)) begin
      valor_s = rotl1(rom_valor(jogada_r));
    end else begin
      valor_s = rom_valor(jogada_r);
    end
  end

  // Next-state logic; a game result overrides every phase transition
  always_comb begin
    estado_s    = estado_r;
    rodada_s    = rodada_r;
    jogada_s    = jogada_r;
    resultado_s = resultado;
    if (monitora_s && perdeu) begin
      estado_s    = FIM;
      resultado_s = 2'b10;
    end else if (monitora_s && ganhou) begin
      estado_s    = FIM;
      resultado_s = 2'b01;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (iniciar) begin
            rodada_s    = 4'd0;
            jogada_s    = 4'd0;
            resultado_s = 2'b00;
            estado_s    = INICIA;
          end else begin
            estado_s = OCIOSO;
          end
        end
        INICIA:    if (contador_r == START_LIM) estado_s = ESPERA;    else estado_s = INICIA;
        ESPERA:    if (contador_r == GAP_LIM)   estado_s = PRESSIONA; else estado_s = ESPERA;
        PRESSIONA: if (contador_r == PRESS_LIM) estado_s = SOLTA;     else estado_s = PRESSIONA;
        SOLTA:     if (contador_r == GAP_LIM)   estado_s = PROXIMA;   else estado_s = SOLTA;
        PROXIMA: begin
          // r=15 is tested before incrementing, so neither index ever wraps
          if (jogada_r < rodada_r) begin
            jogada_s = jogada_r + 4'd1;
            estado_s = PRESSIONA;
          end else if (rodada_r < 4'd15) begin
            rodada_s = rodada_r + 4'd1;
            jogada_s = 4'd0;
            estado_s = PRESSIONA;
          end else begin
            estado_s = AGUARDA;
          end
        end
        AGUARDA: begin
          if (contador_r == WAIT_LIM) begin
            resultado_s = 2'b11;
            estado_s    = FIM;
          end else begin
            estado_s = AGUARDA;
          end
        end
        FIM:     if (!iniciar) estado_s = OCIOSO; else estado_s = FIM;
        default: estado_s = OCIOSO;
      endcase
    end
    if (estado_s != estado_r) contador_s = 8'd0;
    else                      contador_s = contador_r + 8'd1;
  end

  // State, indices, phase counter and result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r   <= OCIOSO;
      rodada_r   <= 4'd0;
      jogada_r   <= 4'd0;
      contador_r <= 8'd0;
      resultado  <= 2'b00;
    end else begin
      estado_r   <= estado_s;
      rodada_r   <= rodada_s;
      jogada_r   <= jogada_s;
      contador_r <= contador_s;
      resultado  <= resultado_s;
    end
  end

  // Registered outputs decoded from the current state; a detected result drops the press at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogar     <= 1'b0;
      botoes    <= 4'b0000;
      ativo     <= 1'b0;
      fim       <= 1'b0;
      db_rodada <= 4'd0;
      db_jogada <= 4'd0;
      db_estado <= 3'd0;
    end else begin
      jogar     <= (estado_r == INICIA);
      botoes    <= ((estado_r == PRESSIONA) && !detecta_s) ? valor_s : 4'b0000;
      ativo     <= monitora_s;
      fim       <= (estado_r == FIM);
      db_rodada <= rodada_r;
      db_jogada <= jogada_r;
      db_estado <= estado_r;
    end
  end

endmodule

// File: tb/tb_jogador_automatico_exp6.sv
// Scoreboard bench: the stimulus pushes the expected press sequence and outcome, a monitor
// pops and compares them while also acting as the game circuit (driving ganhou/perdeu).
`timescale 1ns/1ps
module tb_jogador_automatico_exp6;

  localparam int PRESS = 5;
  localparam int GAP   = 5;
  localparam int START = 5;
  localparam int WAITC = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sel = 1'b0;
  logic ini = 1'b0;
  logic gan = 1'b0;
  logic per = 1'b0;

  logic       ini_d, gan_d, per_d, jogar_d, ativo_d, fim_d;
  logic [3:0] botoes_d, rod_d, jog_d;
  logic [1:0] res_d;
  logic [2:0] est_d;
  logic       ini_e, gan_e, per_e, jogar_e, ativo_e, fim_e;
  logic [3:0] botoes_e, rod_e, jog_e;
  logic [1:0] res_e;
  logic [2:0] est_e;

  logic [3:0] m_botoes;
  logic       m_jogar, m_fim;
  logic [1:0] m_res;
  logic [2:0] m_est;

  always #5 clock = ~clock;

  jogador_automatico_exp6 dut (
    .clock(clock), .reset(reset), .iniciar(ini_d), .ganhou(gan_d), .perdeu(per_d),
    .jogar(jogar_d), .botoes(botoes_d), .ativo(ativo_d), .fim(fim_d), .resultado(res_d),
    .db_rodada(rod_d), .db_jogada(jog_d), .db_estado(est_d)
  );

  jogador_automatico_exp6 #(.ERRO_RODADA(3), .ERRO_JOGADA(3)) dut_err (
    .clock(clock), .reset(reset), .iniciar(ini_e), .ganhou(gan_e), .perdeu(per_e),
    .jogar(jogar_e), .botoes(botoes_e), .ativo(ativo_e), .fim(fim_e), .resultado(res_e),
    .db_rodada(rod_e), .db_jogada(jog_e), .db_estado(est_e)
  );

  assign ini_d = sel ? 1'b0 : ini;
  assign gan_d = sel ? 1'b0 : gan;
  assign per_d = sel ? 1'b0 : per;
  assign ini_e = sel ? ini : 1'b0;
  assign gan_e = sel ? gan : 1'b0;
  assign per_e = sel ? per : 1'b0;
  assign m_botoes = sel ? botoes_e : botoes_d;
  assign m_jogar  = sel ? jogar_e  : jogar_d;
  assign m_fim    = sel ? fim_e    : fim_d;
  assign m_res    = sel ? res_e    : res_d;
  assign m_est    = sel ? est_e    : est_d;

  logic [3:0] seq_rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_press_q [$];
  logic [1:0] exp_res_q [$];
  int         exp_cnt_q [$];
  int mode = 0;   // 0 silent game, 1 win, 2 lose on wrong press, 3 win+lose at first release
  int done_cnt = 0;
  int press_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor and game-circuit model
  initial begin : monitor
    logic [3:0] prev_b, exp_v;
    logic prev_fim, prev_jog, per_pending, gap_on;
    int release_cnt, width, aguarda_cnt, jog_width, gap_cnt, win_delay, mr, mj;
    prev_b = 4'd0; prev_fim = 1'b0; prev_jog = 1'b0; per_pending = 1'b0; gap_on = 1'b0;
    release_cnt = 0; width = 0; aguarda_cnt = 0; jog_width = 0; gap_cnt = 0; win_delay = 0; mr = 0; mj = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_b = 4'd0; prev_fim = 1'b0; prev_jog = 1'b0; per_pending = 1'b0; gap_on = 1'b0;
        press_cnt = 0; release_cnt = 0; width = 0; aguarda_cnt = 0; jog_width = 0;
        gap_cnt = 0; win_delay = 0; mr = 0; mj = 0; gan = 1'b0; per = 1'b0;
      end else begin
        if (m_jogar) jog_width++;
        if (prev_jog && !m_jogar) begin
          check("jogar_width", jog_width, START);
          jog_width = 0; gap_on = 1'b1; gap_cnt = 0;
        end
        if (gap_on && m_botoes == 4'd0) gap_cnt++;
        if (m_est == 3'd6) aguarda_cnt++;
        if (per_pending) begin
          check("release_after_perdeu", m_botoes, 4'd0);
          per_pending = 1'b0;
        end
        if (win_delay > 0) begin
          win_delay--;
          if (win_delay == 0) gan = 1'b1;
        end
        if (prev_b == 4'd0 && m_botoes != 4'd0) begin
          press_cnt++;
          width = 1;
          if (gap_on) begin
            check("gap_before_first_press", gap_cnt, GAP);
            gap_on = 1'b0;
          end
          if (exp_press_q.size() == 0) begin
            check("unexpected_press", m_botoes, 4'd0);
          end else begin
            exp_v = exp_press_q.pop_front();
            check($sformatf("press_%0d", press_cnt), m_botoes, exp_v);
          end
          if (mode == 2 && m_botoes != seq_rom[mj]) begin
            per = 1'b1;
            per_pending = 1'b1;
          end
          if (mj < mr) mj++;
          else begin mr++; mj = 0; end
        end else if (m_botoes != 4'd0) begin
          width++;
        end
        if (prev_b != 4'd0 && m_botoes == 4'd0) begin
          release_cnt++;
          if (mode == 1) check("press_width", width, PRESS);
          if (mode == 1 && release_cnt == 136) win_delay = 3;
          if (mode == 3 && release_cnt == 1) begin gan = 1'b1; per = 1'b1; end
        end
        if (!prev_fim && m_fim) begin
          if (exp_res_q.size() == 0) check("unexpected_fim", 32'd1, 32'd0);
          else check("resultado", m_res, exp_res_q.pop_front());
          if (exp_cnt_q.size() != 0) check("press_count", press_cnt, exp_cnt_q.pop_front());
          if (mode == 0) check("aguarda_cycles", aguarda_cnt, WAITC);
          gan = 1'b0; per = 1'b0; press_cnt = 0; release_cnt = 0; aguarda_cnt = 0; mr = 0; mj = 0;
          done_cnt++;
        end
        prev_b = m_botoes; prev_fim = m_fim; prev_jog = m_jogar;
      end
    end
  end

  task automatic push_expected(input int er, input int ej, input logic [1:0] res, input int npress);
    int n;
    logic [3:0] v;
    n = 0;
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j <= r; j++) begin
        if (n < npress) begin
          v = seq_rom[j];
          if (er < 16 && ej <= er && r == er && j == ej) v = {v[2:0], v[3]};
          exp_press_q.push_back(v);
          n++;
        end
      end
    end
    exp_res_q.push_back(res);
    exp_cnt_q.push_back(npress);
  endtask

  task automatic run_game(input logic s, input int m, input int er, input int ej,
                          input logic [1:0] res, input int npress, input bit hold);
    int d0;
    @(negedge clock);
    sel = s; mode = m;
    push_expected(er, ej, res, npress);
    d0 = done_cnt;
    ini = 1'b1;
    @(negedge clock);
    if (!hold) ini = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clock);
    if (done_cnt == d0) check("game_timeout", 32'd1, 32'd0);
  endtask

  initial begin : stimulus
    repeat (2) @(negedge clock);
    check("rst_jogar", jogar_d, 1'b0);
    check("rst_botoes", botoes_d, 4'd0);
    check("rst_ativo", ativo_d, 1'b0);
    check("rst_fim", fim_d, 1'b0);
    check("rst_resultado", res_d, 2'b00);
    check("rst_db", {rod_d, jog_d, est_d}, 11'd0);
    reset = 1'b1;
    begin
      int jog_hi;
      jog_hi = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (jogar_d) jog_hi++;
      end
      check("idle_no_jogar", jog_hi, 0);
      check("idle_estado", est_d, 3'd0);
    end

    // Reset during the 5th press, then a full winning game from scratch
    sel = 1'b0; mode = 1;
    push_expected(16, 0, 2'b01, 136);
    ini = 1'b1;
    @(negedge clock);
    ini = 1'b0;
    for (int c = 0; c < 2000 && press_cnt != 5; c++) @(negedge clock);
    @(negedge clock);
    check("press5_active", botoes_d, 4'b0010);
    #2 reset = 1'b0;
    #1;
    check("async_rst_botoes", botoes_d, 4'd0);
    check("async_rst_jogar", jogar_d, 1'b0);
    @(negedge clock);
    exp_press_q.delete(); exp_res_q.delete(); exp_cnt_q.delete();
    reset = 1'b1;
    @(negedge clock);
    check("restart_rodada", rod_d, 4'd0);
    check("restart_jogada", jog_d, 4'd0);
    run_game(1'b0, 1, 16, 0, 2'b01, 136, 1'b0);
    repeat (3) @(negedge clock);
    check("win_back_idle", est_d, 3'd0);

    // No response: timeout result
    run_game(1'b0, 0, 16, 0, 2'b11, 136, 1'b0);
    repeat (3) @(negedge clock);

    // Injected error at round 3, play 3
    run_game(1'b1, 2, 3, 3, 2'b10, 10, 1'b0);
    repeat (3) @(negedge clock);
    check("lose_back_idle", est_e, 3'd0);

    // Both flags during SOLTA with iniciar held high
    run_game(1'b0, 3, 16, 0, 2'b10, 1, 1'b1);
    repeat (10) @(negedge clock);
    check("hold_fim", fim_d, 1'b1);
    check("hold_estado", est_d, 3'd7);
    ini = 1'b0;
    repeat (3) @(negedge clock);
    check("release_estado", est_d, 3'd0);
    check("release_fim", fim_d, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jogador_automatico_exp6.md
# jogador_automatico_exp6

Synthesizable automatic player for the exp6 memory game. It drives the `jogar` and `botoes` inputs of `circuito_exp6` and replays the fixed 16-entry game sequence round by round: round r presses entries 0..r. It watches `ganhou`/`perdeu` to report the outcome. It sits beside the game circuit on the FPGA for on-board self-test, and can inject one wrong press at a chosen round and play to exercise the losing path.

## Interface
- `PRESS_CYCLES`, default 5: cycles a button stays pressed; legal range 1..255.
- `GAP_CYCLES`, default 5: released cycles after each press, and after the `jogar` pulse; legal range 1..255.
- `START_CYCLES`, default 5: width of the `jogar` pulse; legal range 1..255.
- `WAIT_CYCLES`, default 64: timeout for the game result after the last press; legal range 1..255.
- `ERRO_RODADA`, default 16: round at which a wrong press is injected; a value ≥16 disables injection.
- `ERRO_JOGADA`, default 0: play index of the injected error; used only when `ERRO_JOGADA` ≤ `ERRO_RODADA`.
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `iniciar` in 1: level-sampled start request; acted on only in OCIOSO.
- `ganhou` in 1: game win flag from `circuito_exp6`.
- `perdeu` in 1: game loss flag from `circuito_exp6`.
- `jogar` out 1: game start pulse to `circuito_exp6`.
- `botoes` out 4: one-hot button press to `circuito_exp6`; 0000 when released.
- `ativo` out 1: high in every state except OCIOSO and FIM.
- `fim` out 1: high in FIM.
- `resultado` out 2: 00 none, 01 won, 10 lost, 11 timeout.
- `db_rodada` out 4: current round r.
- `db_jogada` out 4: current play index j.
- `db_estado` out 3: state code.

## Operation
- Sequence ROM, j = 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Injected wrong value: correct value rotated left by 1. Example: 1000 becomes 0001.
- States and codes:
  - OCIOSO (0): outputs idle. If `iniciar`=1, clear r, j, result and counter, then go to INICIA.
  - INICIA (1): `jogar`=1 for START_CYCLES cycles, then go to ESPERA.
  - ESPERA (2): `jogar`=0 for GAP_CYCLES cycles, then go to PRESSIONA.
  - PRESSIONA (3): `botoes`=ROM[j], or the error value when r=ERRO_RODADA and j=ERRO_JOGADA. Held for PRESS_CYCLES cycles, then go to SOLTA.
  - SOLTA (4): `botoes`=0000 for GAP_CYCLES cycles, then go to PROXIMA.
  - PROXIMA (5), one cycle:
    - if j<r: j←j+1, go to PRESSIONA;
    - else if r<15: r←r+1, j←0, go to PRESSIONA;
    - else go to AGUARDA.
  - AGUARDA (6): wait for `ganhou`/`perdeu`. After WAIT_CYCLES cycles with neither, set `resultado`=11 and go to FIM.
  - FIM (7): hold `resultado`, `fim`=1. Go to OCIOSO when `iniciar`=0.
- Result monitor, states 1–6: `perdeu`=1 sets `resultado`=10 and goes to FIM; otherwise `ganhou`=1 sets 01 and goes to FIM. If both are high, `perdeu` wins.
- A result detected mid-press releases `botoes` the next cycle; the press is not completed.
- Phase counter is 8 bits. It is cleared on every state entry and compared with (param−1).
- r and j are 4 bits and never wrap: the r=15 test precedes the increment.
- `iniciar` held high through FIM: the block stays in FIM. No auto-restart.

## Timing
- Reset values:
  - state OCIOSO, r=j=0, counter=0;
  - `jogar`=0, `botoes`=0000;
  - `ativo`=0, `fim`=0, `resultado`=00;
  - `db_*`=0.
- All outputs are registered: each changes one cycle after the state or counter edge that causes it.
- `iniciar` sampled high in OCIOSO at edge k gives `jogar`=1 from edge k+1 through k+START_CYCLES.
- Each play takes PRESS_CYCLES+GAP_CYCLES+1 cycles.
- With defaults and no error, a full game is 5+5 + 136·11 = 1506 cycles, plus the AGUARDA time.
- The `ganhou`/`perdeu` reaction is 1 cycle: FIM and `resultado` are visible at the next edge.
- `reset` low at any point, including mid-press, forces `botoes`=0000 and `jogar`=0 immediately (asynchronous).

## Test plan
- Reset low for 2 cycles, then high. Required: all outputs at their reset values and `db_estado`=0. With `iniciar`=0 for 20 cycles, `jogar` stays 0.
- Defaults; `iniciar` pulsed; the bench model asserts `ganhou` 3 cycles after the 136th release. Required: exactly 136 presses in the ROM order (round 2 = 0001, 0010, 0100), then `resultado`=01 and `fim`=1.
- `ERRO_RODADA`=3, `ERRO_JOGADA`=3; the model raises `perdeu` on a wrong press. Required: the 10th press is 0001 instead of 1000, then `resultado`=10, with `botoes`=0000 the cycle after `perdeu`.
- No response from the model. Required: after the last release, AGUARDA lasts 64 cycles, then `resultado`=11.
- `reset` driven low during the 5th press. Required: `botoes`=0000 asynchronously; after release and a new `iniciar`, play restarts from r=0, j=0.
- `ganhou` and `perdeu` asserted in the same cycle during SOLTA. Required: `resultado`=10. With `iniciar` held high in FIM, the block stays in FIM until `iniciar`=0, then returns to OCIOSO.
